// File: rtl/pcie_lane_rx_decoder.sv
// Per-lane 8b/10b receive decoder: symbol decode, running-disparity tracking,
// COM-based lock acquisition and a saturating code/disparity error counter.
module pcie_lane_rx_decoder #(
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned UNLOCK_ERRS = 4,
   parameter int unsigned ERRCNT_W    = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [9:0]          LinkIn,
   input  logic                ClrErr,
   output logic [7:0]          Data,
   output logic                KFlag,
   output logic                DataValid,
   output logic                CodeErr,
   output logic                DispErr,
   output logic                Locked,
   output logic [ERRCNT_W-1:0] ErrCount
);

   localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned BadW  = $clog2(UNLOCK_ERRS + 1);

   typedef enum logic [1:0] {StUnlocked, StCheck, StLocked} lockState_t;

   lockState_t          stateQ, stateD;
   logic [GoodW-1:0]    goodQ, goodD;
   logic [BadW-1:0]     badQ, badD;
   logic                rdQ, rdD;
   logic [ERRCNT_W-1:0] errCntQ, errCntD;
   logic [7:0]          dataQ;
   logic                kQ, validQ, codeErrQ, dispErrQ;

   logic [5:0] abcdei;
   logic [3:0] fghj, fghjN;
   logic [4:0] x;
   logic [2:0] y;
   logic [2:0] ones6, ones4;
   logic       valid6, valid4, isK28, kx7, p7, a7, ei11, ei00, pairOk, isK;
   logic       nz6, pos6, nz4, pos4, rdMid, rdNew, rawDisp;
   logic       codeErr, dispErr, isCom, symErr;

   // Reorder so case literals read in transmission order (a..i, f..j).
   assign abcdei = {LinkIn[0], LinkIn[1], LinkIn[2], LinkIn[3], LinkIn[4], LinkIn[5]};
   assign fghj   = {LinkIn[6], LinkIn[7], LinkIn[8], LinkIn[9]};

   always_comb begin
      x      = '0;
      valid6 = 1'b1;
      isK28  = 1'b0;
      kx7    = 1'b0;
      case (abcdei)
         6'b100111, 6'b011000: x = 5'd0;
         6'b011101, 6'b100010: x = 5'd1;
         6'b101101, 6'b010010: x = 5'd2;
         6'b110001:            x = 5'd3;
         6'b110101, 6'b001010: x = 5'd4;
         6'b101001:            x = 5'd5;
         6'b011001:            x = 5'd6;
         6'b111000, 6'b000111: x = 5'd7;
         6'b111001, 6'b000110: x = 5'd8;
         6'b100101:            x = 5'd9;
         6'b010101:            x = 5'd10;
         6'b110100:            x = 5'd11;
         6'b001101:            x = 5'd12;
         6'b101100:            x = 5'd13;
         6'b011100:            x = 5'd14;
         6'b010111, 6'b101000: x = 5'd15;
         6'b011011, 6'b100100: x = 5'd16;
         6'b100011:            x = 5'd17;
         6'b010011:            x = 5'd18;
         6'b110010:            x = 5'd19;
         6'b001011:            x = 5'd20;
         6'b101010:            x = 5'd21;
         6'b011010:            x = 5'd22;
         6'b111010, 6'b000101: begin x = 5'd23; kx7 = 1'b1; end
         6'b110011, 6'b001100: x = 5'd24;
         6'b100110:            x = 5'd25;
         6'b010110:            x = 5'd26;
         6'b110110, 6'b001001: begin x = 5'd27; kx7 = 1'b1; end
         6'b001110:            x = 5'd28;
         6'b101110, 6'b010001: begin x = 5'd29; kx7 = 1'b1; end
         6'b011110, 6'b100001: begin x = 5'd30; kx7 = 1'b1; end
         6'b101011, 6'b010100: x = 5'd31;
         6'b001111, 6'b110000: begin x = 5'd28; isK28 = 1'b1; end
         default:              valid6 = 1'b0;
      endcase
   end

   // K28 RD+ forms are the bitwise complement of RD- forms, so fold them onto the D table.
   assign fghjN = (isK28 && abcdei == 6'b110000) ? ~fghj : fghj;

   always_comb begin
      y      = '0;
      valid4 = 1'b1;
      p7     = 1'b0;
      a7     = 1'b0;
      case (fghjN)
         4'b1011, 4'b0100: y = 3'd0;
         4'b1001:          y = 3'd1;
         4'b0101:          y = 3'd2;
         4'b1100, 4'b0011: y = 3'd3;
         4'b1101, 4'b0010: y = 3'd4;
         4'b1010:          y = 3'd5;
         4'b0110:          y = 3'd6;
         4'b1110, 4'b0001: begin y = 3'd7; p7 = 1'b1; end
         4'b0111, 4'b1000: begin y = 3'd7; a7 = 1'b1; end
         default:          valid4 = 1'b0;
      endcase
   end

   always_comb begin
      ei11 = abcdei[1] & abcdei[0];
      ei00 = ~abcdei[1] & ~abcdei[0];
      if (isK28) begin
         pairOk = ~p7;
      end else if (p7) begin
         // P7 would create a run of five after e=i; those slots use A7 instead.
         pairOk = ~((fghj == 4'b1110 && ei11) || (fghj == 4'b0001 && ei00));
      end else if (a7 && !kx7) begin
         pairOk = (fghj == 4'b0111 && ei11) || (fghj == 4'b1000 && ei00);
      end else begin
         pairOk = 1'b1;
      end
      isK     = isK28 | (kx7 & a7);
      codeErr = ~(valid6 & valid4 & pairOk);

      ones6   = 3'($countones(abcdei));
      ones4   = 3'($countones(fghj));
      nz6     = (ones6 != 3'd3);
      pos6    = (ones6 > 3'd3);
      nz4     = (ones4 != 3'd2);
      pos4    = (ones4 > 3'd2);
      rdMid   = nz6 ? pos6 : rdQ;
      rdNew   = nz4 ? pos4 : rdMid;
      rawDisp = (nz6 && pos6 == rdQ) || (nz4 && pos4 == rdMid);
      rdD     = codeErr ? rdQ : rdNew;

      dispErr = ~codeErr & rawDisp & (stateQ != StUnlocked);
      isCom   = ~codeErr & isK & ({y, x} == 8'hBC);
      symErr  = codeErr | dispErr;
   end

   always_comb begin
      stateD = stateQ;
      goodD  = goodQ;
      badD   = '0;
      unique case (stateQ)
         StUnlocked: begin
            goodD = '0;
            if (isCom) begin
               stateD = StCheck;
               goodD  = GoodW'(1);
            end
         end
         StCheck: begin
            if (symErr) begin
               stateD = StUnlocked;
               goodD  = '0;
            end else if (goodQ + 1'b1 == GoodW'(LOCK_COUNT)) begin
               stateD = StLocked;
               goodD  = '0;
            end else begin
               goodD = goodQ + 1'b1;
            end
         end
         StLocked: begin
            if (symErr) begin
               if (badQ + 1'b1 == BadW'(UNLOCK_ERRS)) begin
                  stateD = StUnlocked;
               end else begin
                  badD = badQ + 1'b1;
               end
            end
         end
         default: stateD = StUnlocked;
      endcase

      errCntD = errCntQ;
      if (ClrErr) begin
         errCntD = '0;
      end else if (symErr && stateQ != StUnlocked && !(&errCntQ)) begin
         errCntD = errCntQ + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ   <= StUnlocked;
         goodQ    <= '0;
         badQ     <= '0;
         rdQ      <= 1'b0;
         errCntQ  <= '0;
         dataQ    <= '0;
         kQ       <= 1'b0;
         validQ   <= 1'b0;
         codeErrQ <= 1'b0;
         dispErrQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         goodQ    <= goodD;
         badQ     <= badD;
         rdQ      <= rdD;
         errCntQ  <= errCntD;
         dataQ    <= codeErr ? 8'h00 : {y, x};
         kQ       <= ~codeErr & isK;
         validQ   <= (stateD == StLocked) & ~codeErr;
         codeErrQ <= codeErr;
         dispErrQ <= dispErr;
      end
   end

   assign Data      = dataQ;
   assign KFlag     = kQ;
   assign DataValid = validQ;
   assign CodeErr   = codeErrQ;
   assign DispErr   = dispErrQ;
   assign Locked    = (stateQ == StLocked);
   assign ErrCount  = errCntQ;

endmodule

// File: tb/tb_pcie_lane_rx_decoder.sv
// Scoreboard bench for pcie_lane_rx_decoder: directed symbols push expected outputs,
// a negedge monitor pops and compares them one registered stage later.
module tb_pcie_lane_rx_decoder;

   localparam int EW     = 8;
   localparam int ErrMax = (1 << EW) - 1;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic [9:0]    LinkIn = 10'h000;
   logic          ClrErr = 1'b0;
   logic [7:0]    Data;
   logic          KFlag, DataValid, CodeErr, DispErr, Locked;
   logic [EW-1:0] ErrCount;

   pcie_lane_rx_decoder #(
      .LOCK_COUNT (4),
      .UNLOCK_ERRS(4),
      .ERRCNT_W   (EW)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .LinkIn   (LinkIn),
      .ClrErr   (ClrErr),
      .Data     (Data),
      .KFlag    (KFlag),
      .DataValid(DataValid),
      .CodeErr  (CodeErr),
      .DispErr  (DispErr),
      .Locked   (Locked),
      .ErrCount (ErrCount)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [7:0]    data;
      logic          k;
      logic          dv;
      logic          ce;
      logic          de;
      logic          lk;
      logic [EW-1:0] cnt;
   } obs_t;

   typedef struct {
      int    due;
      obs_t  exp;
      string name;
   } item_t;

   item_t sb[$];
   int    cyc = 0;
   int    nCmp = 0;
   int    nBad = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic obs_t sample();
      return {Data, KFlag, DataValid, CodeErr, DispErr, Locked, ErrCount};
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s @%0t: got data=%h k=%b dv=%b ce=%b de=%b lk=%b cnt=%0d, want data=%h k=%b dv=%b ce=%b de=%b lk=%b cnt=%0d",
                  name, $time, act.data, act.k, act.dv, act.ce, act.de, act.lk, act.cnt,
                  exp.data, exp.k, exp.dv, exp.ce, exp.de, exp.lk, exp.cnt);
      end
   endtask

   // Monitor: output for a symbol driven after edge N is due after edge N+1.
   always @(negedge Clk) begin
      item_t it;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         it = sb.pop_front();
         check(it.name, sample(), it.exp);
      end
   end

   task automatic send(input logic [9:0] sym, input logic clr, input string name,
                       input logic [7:0] d, input logic k, input logic dv, input logic ce,
                       input logic de, input logic lk, input int cnt);
      item_t it;
      @(posedge Clk);
      #1;
      LinkIn   = sym;
      ClrErr   = clr;
      it.due   = cyc + 1;
      it.exp   = {d, k, dv, ce, de, lk, cnt[EW-1:0]};
      it.name  = name;
      sb.push_back(it);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() > 0 && t < 20) begin
         @(negedge Clk);
         #1;
         t++;
      end
      nCmp++;
      if (sb.size() > 0) begin
         nBad++;
         $display("FAIL %s: %0d expected outputs never observed, want 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_init", sample(), '0);
      @(negedge Clk);
      Reset = 1'b0;

      // Acquire lock from an RD- COM, then exercise data/K decode while locked.
      send(10'h17C, 0, "a1_com",      8'hBC, 1, 0, 0, 0, 0, 0);
      send(10'h346, 0, "a2_check",    8'h00, 0, 0, 0, 0, 0, 0);
      send(10'h346, 0, "a3_check",    8'h00, 0, 0, 0, 0, 0, 0);
      send(10'h346, 0, "a4_lock",     8'h00, 0, 1, 0, 0, 1, 0);
      send(10'h283, 0, "a5_com_lk",   8'hBC, 1, 1, 0, 0, 1, 0);
      send(10'h0B9, 0, "a6_d00_rdm",  8'h00, 0, 1, 0, 0, 1, 0);
      send(10'h17C, 0, "a7_com_lk",   8'hBC, 1, 1, 0, 0, 1, 0);
      send(10'h155, 0, "a8_d21_5",    8'hB5, 0, 1, 0, 0, 1, 0);
      send(10'h3A8, 0, "a9_k23_7",    8'hF7, 1, 1, 0, 0, 1, 0);
      send(10'h0B9, 0, "a10_disperr", 8'h00, 0, 1, 0, 1, 1, 1);
      send(10'h3B1, 0, "a11_d17_a7",  8'hF1, 0, 1, 0, 0, 1, 1);
      // Four code errors drop lock with the fourth; the fifth is not counted.
      send(10'h000, 0, "a12_cerr1",   8'h00, 0, 0, 1, 0, 1, 2);
      send(10'h000, 0, "a13_cerr2",   8'h00, 0, 0, 1, 0, 1, 3);
      send(10'h000, 0, "a14_cerr3",   8'h00, 0, 0, 1, 0, 1, 4);
      send(10'h000, 0, "a15_unlock",  8'h00, 0, 0, 1, 0, 0, 5);
      send(10'h000, 0, "a16_nocount", 8'h00, 0, 0, 1, 0, 0, 5);

      // Error during CHECK aborts acquisition; DispErr hidden while unlocked.
      send(10'h17C, 0, "b1_com",      8'hBC, 1, 0, 0, 0, 0, 5);
      send(10'h346, 0, "b2_check",    8'h00, 0, 0, 0, 0, 0, 5);
      send(10'h3FF, 0, "b3_ones",     8'h00, 0, 0, 1, 0, 0, 6);
      send(10'h346, 0, "b4_ignored",  8'h00, 0, 0, 0, 0, 0, 6);
      send(10'h0B9, 0, "b5_nodisp",   8'h00, 0, 0, 0, 0, 0, 6);
      send(10'h283, 0, "b6_com_load", 8'hBC, 1, 0, 0, 0, 0, 6);
      send(10'h0B9, 0, "b7_check",    8'h00, 0, 0, 0, 0, 0, 6);
      send(10'h0B9, 0, "b8_check",    8'h00, 0, 0, 0, 0, 0, 6);
      send(10'h0B9, 0, "b9_relock",   8'h00, 0, 1, 0, 0, 1, 6);

      // Drive ErrCount to saturation with bursts of three errors that keep lock.
      cnt = 6;
      for (int i = 0; i < 83; i++) begin
         for (int j = 0; j < 3; j++) begin
            cnt = (cnt < ErrMax) ? cnt + 1 : cnt;
            send(10'h000, 0, "sat_err", 8'h00, 0, 0, 1, 0, 1, cnt);
         end
         send(10'h0B9, 0, "sat_good", 8'h00, 0, 1, 0, 0, 1, cnt);
      end
      send(10'h000, 0, "c1_saturated", 8'h00, 0, 0, 1, 0, 1, ErrMax);
      send(10'h000, 1, "c2_clr_prio",  8'h00, 0, 0, 1, 0, 1, 0);
      send(10'h0B9, 0, "c3_good",      8'h00, 0, 1, 0, 0, 1, 0);
      drain("drain_c");

      // Short asynchronous reset pulse between clock edges.
      Reset = 1'b1;
      #1;
      check("reset_async", sample(), '0);
      #1;
      Reset = 1'b0;

      send(10'h283, 0, "d1_com_rdp", 8'hBC, 1, 0, 0, 0, 0, 0);
      send(10'h0B9, 0, "d2_check",   8'h00, 0, 0, 0, 0, 0, 0);
      send(10'h0B9, 0, "d3_check",   8'h00, 0, 0, 0, 0, 0, 0);
      send(10'h0B9, 0, "d4_relock",  8'h00, 0, 1, 0, 0, 1, 0);
      drain("drain_d");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/pcie_lane_rx_decoder.md
Name: pcie_lane_rx_decoder

Overview:
- Per-lane receive front end for the 10-bit PCIe serial link. Converts one 10-bit lane symbol per clock back to a byte plus K flag.
- Tracks running disparity, acquires and holds symbol lock on COM (K28.5), and counts code and disparity errors.
- Sits between a 10-bit LinkIn lane bus and the data-link/ordered-set logic. It is the decode counterpart of the per-lane 8b/10b transmit encoder, instantiated once per lane.

Parameters:
- LOCK_COUNT, 4: consecutive error-free symbols (COM included) needed to reach LOCKED.
- UNLOCK_ERRS, 4: consecutive erroneous symbols that drop LOCKED back to UNLOCKED.
- ERRCNT_W, 16: width of the saturating error counter.

Ports:
- Clk  in  1  lane symbol clock; one symbol per rising edge.
- Reset  in  1  asynchronous reset, active-high.
- LinkIn  in  10  received symbol. abcdei = LinkIn[5:0] with a = bit 0; fghj = LinkIn[9:6] with f = bit 6.
- ClrErr  in  1  synchronous clear of ErrCount.
- Data  out  8  decoded byte HGFEDCBA, A = bit 0.
- KFlag  out  1  decoded symbol is a valid K code.
- DataValid  out  1  Data/KFlag are valid (Locked and no CodeErr).
- CodeErr  out  1  symbol not in the 8b/10b table, or invalid 6b/4b pairing.
- DispErr  out  1  symbol legal but wrong for the current running disparity.
- Locked  out  1  lock FSM in LOCKED.
- ErrCount  out  ERRCNT_W  saturating count of symbols with CodeErr or DispErr while not UNLOCKED.

Behaviour:
- Reset values:
  - All outputs 0; ErrCount 0.
  - FSM = UNLOCKED; RD = negative; consecutive-good and consecutive-bad counters 0.
- Latency: one registered stage. LinkIn sampled at edge N appears on Data/KFlag/flags/DataValid after edge N+1 (visible in cycle N+1).
- Decode: standard 5b/6b and 3b/4b tables, including K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7. D.x.A7 alternates are accepted. Any other code asserts CodeErr; Data is then 0x00 and KFlag 0.
- Running disparity:
  - Evaluated per sub-block: 6b then 4b.
  - A non-neutral sub-block must oppose the current RD, otherwise DispErr.
  - RD is updated from received sub-block disparity even on DispErr. RD is held on CodeErr.
  - In UNLOCKED, DispErr is suppressed and RD is loaded from each COM: 0x17C (RD- form) sets RD+ after the symbol; 0x283 (RD+ form) sets RD-.
- Lock FSM:
  - UNLOCKED: on COM → CHECK with good count = 1. All other symbols are ignored.
  - CHECK:
    - Error-free symbol: increment good count; at good count = LOCK_COUNT → LOCKED.
    - Any error → UNLOCKED, counters cleared.
    - A further COM is counted as good.
  - LOCKED:
    - Each erroneous symbol increments bad count; an error-free symbol clears it.
    - Bad count reaching UNLOCK_ERRS → UNLOCKED (Locked drops in the same registered stage as the last error).
  - Locked = 1 only in LOCKED. DataValid = Locked AND NOT CodeErr. A DispErr symbol is still reported valid, with DispErr set.
- ErrCount:
  - Increments by 1 per symbol with CodeErr OR DispErr, in CHECK or LOCKED.
  - Saturates at all-ones.
  - ClrErr has priority over a simultaneous increment (result 0).
- Boundaries:
  - A comma seen while LOCKED is an ordinary good symbol; no realignment and no RD reload.
  - Reset asserted mid-stream clears outputs immediately (asynchronous). Lock is re-acquired from UNLOCKED after release.
  - An all-zero or all-ones LinkIn (idle/undriven) is a CodeErr.

Test Plan:
- After Reset release, drive 0x17C, then 0x346 ×4 (D0.0 RD+ then alternating correctly), 0x0B9 where RD requires it → Locked rises 1 cycle after the 4th good symbol; Data = 0x00, KFlag = 0, no errors; COM output is Data = 0xBC, KFlag = 1.
- While locked with RD+, drive 0x0B9 (D0.0 RD- form) → DispErr = 1, DataValid = 1, Data = 0x00, ErrCount increments by 1, Locked stays 1.
- While locked, drive 0x000 ×4 → CodeErr each cycle, DataValid = 0; Locked falls with the 4th error; ErrCount += 4. A subsequent 0x000 does not increment ErrCount.
- In CHECK (after 0x17C and 1 good symbol), drive one 0x3FF → returns to UNLOCKED; Locked never asserts until a new COM plus 3 good symbols.
- Preload ErrCount to saturation (2^16 − 1 errors, or force), inject one more error → stays 0xFFFF. Assert ClrErr coincident with an error → 0x0000.
- Assert Reset for a partial cycle while LOCKED → all outputs 0 without waiting for Clk. After release, 0x283 (RD+ COM) then correct RD- data ×3 → re-lock.
